// File: rtl/hazard_ctrl.sv
// hazard_ctrl: tracks the destination register of every post-decode stage and derives
// registered forwarding distances, load-use stalls and post-redirect decode kills.
module hazard_ctrl #(
    parameter int  REG_ADDR_W  = 5,
    parameter int  NUM_STAGES  = 2,
    parameter int  LOAD_LAT    = 1,
    parameter int  KILL_CYCLES = 1,
    localparam int FW          = $clog2(NUM_STAGES + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_rs1_used,
    input  logic                  id_rs2_used,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_rd_we,
    input  logic                  id_is_load,
    input  logic                  redirect,
    output logic                  id_stall,
    output logic                  id_kill,
    output logic [FW-1:0]         fwd_dist_a,
    output logic [FW-1:0]         fwd_dist_b,
    output logic                  x_valid,
    output logic                  wb_we,
    output logic [REG_ADDR_W-1:0] wb_rd
);
    localparam int KCW = (KILL_CYCLES > 1) ? $clog2(KILL_CYCLES) : 1;

    logic [NUM_STAGES:1]   valid_q, valid_d;
    logic [NUM_STAGES:1]   we_q, we_d;
    logic [NUM_STAGES:1]   load_q, load_d;
    logic [REG_ADDR_W-1:0] rd_q [1:NUM_STAGES];
    logic [KCW-1:0]        kill_cnt_q, kill_cnt_d;
    logic [FW-1:0]         fwd_a_q, fwd_a_d;
    logic [FW-1:0]         fwd_b_q, fwd_b_d;
    logic [FW-1:0]         dist_a, dist_b;
    logic                  hazard;
    logic                  issue;

    always_comb begin
        dist_a = '0;
        dist_b = '0;
        hazard = 1'b0;
        // Walk from the oldest stage to the youngest so the youngest match wins.
        for (int k = NUM_STAGES; k >= 1; k--) begin
            if (id_rs1_used && (id_rs1 != '0) && valid_q[k] && we_q[k] && (rd_q[k] == id_rs1)) begin
                dist_a = FW'(k);
                if (load_q[k] && (k <= LOAD_LAT)) hazard = 1'b1;
            end
            if (id_rs2_used && (id_rs2 != '0) && valid_q[k] && we_q[k] && (rd_q[k] == id_rs2)) begin
                dist_b = FW'(k);
                if (load_q[k] && (k <= LOAD_LAT)) hazard = 1'b1;
            end
        end
    end

    // A kill outranks a stall so a squashed load-use consumer drains as a bubble.
    assign id_kill  = !reset && (redirect || (kill_cnt_q != '0));
    assign id_stall = !reset && id_valid && hazard && !id_kill;
    assign issue    = id_valid && !id_stall && !id_kill;

    always_comb begin
        valid_d = {valid_q[NUM_STAGES-1:1], issue};
        we_d    = {we_q[NUM_STAGES-1:1], issue && id_rd_we};
        load_d  = {load_q[NUM_STAGES-1:1], issue && id_is_load};
        fwd_a_d = issue ? dist_a : '0;
        fwd_b_d = issue ? dist_b : '0;
        kill_cnt_d = kill_cnt_q;
        if (redirect) begin
            kill_cnt_d = KCW'(KILL_CYCLES - 1);
        end else if (kill_cnt_q != '0) begin
            kill_cnt_d = kill_cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q    <= '0;
            we_q       <= '0;
            load_q     <= '0;
            kill_cnt_q <= '0;
            fwd_a_q    <= '0;
            fwd_b_q    <= '0;
        end else begin
            valid_q    <= valid_d;
            we_q       <= we_d;
            load_q     <= load_d;
            kill_cnt_q <= kill_cnt_d;
            fwd_a_q    <= fwd_a_d;
            fwd_b_q    <= fwd_b_d;
        end
    end

    // Register numbers are qualified by valid everywhere, so they need no reset.
    always_ff @(posedge clk) begin
        rd_q[1] <= id_rd;
        for (int k = 2; k <= NUM_STAGES; k++) begin
            rd_q[k] <= rd_q[k-1];
        end
    end

    assign fwd_dist_a = fwd_a_q;
    assign fwd_dist_b = fwd_b_q;
    assign x_valid    = valid_q[1];
    assign wb_we      = valid_q[NUM_STAGES] && we_q[NUM_STAGES] && (rd_q[NUM_STAGES] != '0);
    assign wb_rd      = valid_q[NUM_STAGES] ? rd_q[NUM_STAGES] : '0;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: two configurations (2 stages / load 1 / kill 2 and
// 4 stages / load 2 / kill 1) share one stimulus stream and an issue-history model.
`timescale 1ns/1ps
module tb_hazard_ctrl;
    logic       clk = 1'b0;
    logic       reset, id_valid, id_rs1_used, id_rs2_used, id_rd_we, id_is_load, redirect;
    logic [4:0] id_rs1, id_rs2, id_rd;
    logic       st0, kl0, xv0, we0;
    logic [1:0] fa0, fb0;
    logic [4:0] wr0;
    logic       st1, kl1, xv1, we1;
    logic [2:0] fa1, fb1;
    logic [4:0] wr1;
    int         checks = 0;
    int         errors = 0;

    typedef struct packed { bit v; bit [4:0] rd; bit we; bit ld; } ent_t;
    ent_t hist [2][8];
    int   m_ns [2] = '{2, 4};
    int   m_ll [2] = '{1, 2};
    int   m_kc [2] = '{2, 1};
    int   kr [2];
    bit   e_st [2], e_kl [2], e_xv [2];
    int   c_fa [2], c_fb [2], e_fa [2], e_fb [2];

    always #5 clk = ~clk;

    hazard_ctrl #(.REG_ADDR_W(5), .NUM_STAGES(2), .LOAD_LAT(1), .KILL_CYCLES(2)) dut0 (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd(id_rd), .id_rd_we(id_rd_we),
        .id_is_load(id_is_load), .redirect(redirect), .id_stall(st0), .id_kill(kl0),
        .fwd_dist_a(fa0), .fwd_dist_b(fb0), .x_valid(xv0), .wb_we(we0), .wb_rd(wr0));

    hazard_ctrl #(.REG_ADDR_W(5), .NUM_STAGES(4), .LOAD_LAT(2), .KILL_CYCLES(1)) dut1 (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd(id_rd), .id_rd_we(id_rd_we),
        .id_is_load(id_is_load), .redirect(redirect), .id_stall(st1), .id_kill(kl1),
        .fwd_dist_a(fa1), .fwd_dist_b(fb1), .x_valid(xv1), .wb_we(we1), .wb_rd(wr1));

    // Entry k of the history is the issue record from k cycles ago.
    function automatic void model_eval();
        for (int c = 0; c < 2; c++) begin
            bit hz;
            hz = 1'b0;
            c_fa[c] = 0;
            c_fb[c] = 0;
            for (int k = 1; k <= m_ns[c]; k++) begin
                if (id_rs1_used && id_rs1 != 0 && hist[c][k].v && hist[c][k].we && hist[c][k].rd == id_rs1) begin
                    if (c_fa[c] == 0) c_fa[c] = k;
                    if (hist[c][k].ld && k <= m_ll[c]) hz = 1'b1;
                end
                if (id_rs2_used && id_rs2 != 0 && hist[c][k].v && hist[c][k].we && hist[c][k].rd == id_rs2) begin
                    if (c_fb[c] == 0) c_fb[c] = k;
                    if (hist[c][k].ld && k <= m_ll[c]) hz = 1'b1;
                end
            end
            e_kl[c] = !reset && (redirect || kr[c] > 0);
            e_st[c] = !reset && id_valid && hz && !e_kl[c];
        end
    endfunction

    function automatic void model_clear();
        for (int c = 0; c < 2; c++) begin
            for (int k = 0; k < 8; k++) hist[c][k] = '0;
            kr[c] = 0; e_xv[c] = 1'b0; e_fa[c] = 0; e_fb[c] = 0;
        end
    endfunction

    function automatic void model_commit();
        model_eval();
        if (reset) begin
            model_clear();
        end else begin
            for (int c = 0; c < 2; c++) begin
                bit iss;
                iss = id_valid && !e_st[c] && !e_kl[c];
                for (int k = m_ns[c]; k >= 2; k--) hist[c][k] = hist[c][k-1];
                hist[c][1].v  = iss;
                hist[c][1].rd = id_rd;
                hist[c][1].we = id_rd_we;
                hist[c][1].ld = id_is_load;
                e_xv[c] = iss;
                e_fa[c] = iss ? c_fa[c] : 0;
                e_fb[c] = iss ? c_fb[c] : 0;
                if (redirect) kr[c] = m_kc[c] - 1;
                else if (kr[c] > 0) kr[c] = kr[c] - 1;
            end
        end
    endfunction

    task automatic cyc(input bit v, input int rs1, input int rs2, input bit u1, input bit u2,
                       input int rd, input bit we, input bit ld, input bit rdr);
        model_commit();
        @(negedge clk);
        id_valid = v; id_rs1 = 5'(rs1); id_rs2 = 5'(rs2); id_rs1_used = u1; id_rs2_used = u2;
        id_rd = 5'(rd); id_rd_we = we; id_is_load = ld; redirect = rdr;
        #1;
        model_eval();
    endtask

    task automatic flush();
        for (int i = 0; i < 6; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_reset();
        reset = 1'b1; redirect = 1'b1; id_valid = 1'b1; id_rs1 = 5'd1; id_rs1_used = 1'b1;
        id_rs2 = 5'd0; id_rs2_used = 1'b0; id_rd = 5'd1; id_rd_we = 1'b1; id_is_load = 1'b1;
        @(negedge clk); @(negedge clk); #1;
        checks++; if (kl0 !== 1'b0) begin errors++; $display("FAIL rst_kill0 got=%0b exp=0", kl0); end
        checks++; if (kl1 !== 1'b0) begin errors++; $display("FAIL rst_kill1 got=%0b exp=0", kl1); end
        checks++; if (st0 !== 1'b0) begin errors++; $display("FAIL rst_stall0 got=%0b exp=0", st0); end
        checks++; if (xv0 !== 1'b0) begin errors++; $display("FAIL rst_xv0 got=%0b exp=0", xv0); end
        checks++; if (fa0 !== 2'd0 || fb0 !== 2'd0) begin errors++; $display("FAIL rst_fwd0 got=%0d/%0d exp=0/0", fa0, fb0); end
        checks++; if (we0 !== 1'b0 || wr0 !== 5'd0) begin errors++; $display("FAIL rst_wb0 got=%0b/%0d exp=0/0", we0, wr0); end
        checks++; if (xv1 !== 1'b0 || we1 !== 1'b0) begin errors++; $display("FAIL rst_out1 got=%0b/%0b exp=0/0", xv1, we1); end
        redirect = 1'b0; id_valid = 1'b0; id_rs1_used = 1'b0; id_rd_we = 1'b0; id_is_load = 1'b0;
        model_clear();
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_back_to_back();
        flush();
        cyc(1, 0, 0, 0, 0, 5, 1, 0, 0);
        cyc(1, 5, 5, 1, 1, 6, 1, 0, 0);
        checks++; if (st0 !== 1'b0) begin errors++; $display("FAIL b2b_stall0 got=%0b exp=0", st0); end
        checks++; if (xv0 !== 1'b1 || fa0 !== 2'd0) begin errors++; $display("FAIL b2b_prod0 got=%0b/%0d exp=1/0", xv0, fa0); end
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
        checks++; if (xv0 !== 1'b1) begin errors++; $display("FAIL b2b_xv0 got=%0b exp=1", xv0); end
        checks++; if (fa0 !== 2'd1 || fb0 !== 2'd1) begin errors++; $display("FAIL b2b_fwd0 got=%0d/%0d exp=1/1", fa0, fb0); end
        checks++; if (fa1 !== 3'd1 || fb1 !== 3'd1) begin errors++; $display("FAIL b2b_fwd1 got=%0d/%0d exp=1/1", fa1, fb1); end
    endtask

    task automatic test_load_use();
        flush();
        cyc(1, 0, 0, 0, 0, 7, 1, 1, 0);
        cyc(1, 7, 0, 1, 1, 8, 1, 0, 0);
        checks++; if (st0 !== 1'b1) begin errors++; $display("FAIL lu_stall0_c1 got=%0b exp=1", st0); end
        checks++; if (st1 !== 1'b1) begin errors++; $display("FAIL lu_stall1_c1 got=%0b exp=1", st1); end
        cyc(1, 7, 0, 1, 1, 8, 1, 0, 0);
        checks++; if (st0 !== 1'b0) begin errors++; $display("FAIL lu_stall0_c2 got=%0b exp=0", st0); end
        checks++; if (xv0 !== 1'b0) begin errors++; $display("FAIL lu_bubble0 got=%0b exp=0", xv0); end
        checks++; if (st1 !== 1'b1) begin errors++; $display("FAIL lu_stall1_c2 got=%0b exp=1", st1); end
        cyc(1, 7, 0, 1, 1, 8, 1, 0, 0);
        checks++; if (xv0 !== 1'b1 || fa0 !== 2'd2 || fb0 !== 2'd0) begin errors++; $display("FAIL lu_fwd0 got=%0b/%0d/%0d exp=1/2/0", xv0, fa0, fb0); end
        checks++; if (st1 !== 1'b0 || xv1 !== 1'b0) begin errors++; $display("FAIL lu_c3_1 got=%0b/%0b exp=0/0", st1, xv1); end
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
        checks++; if (xv1 !== 1'b1 || fa1 !== 3'd3 || fb1 !== 3'd0) begin errors++; $display("FAIL lu_fwd1 got=%0b/%0d/%0d exp=1/3/0", xv1, fa1, fb1); end
        checks++; if (fa0 !== 2'd0) begin errors++; $display("FAIL lu_untracked0 got=%0d exp=0", fa0); end
    endtask

    task automatic test_x0_unused();
        flush();
        cyc(1, 0, 0, 0, 0, 0, 1, 1, 0);
        cyc(1, 0, 0, 1, 0, 9, 1, 1, 0);
        checks++; if (st0 !== 1'b0 || st1 !== 1'b0) begin errors++; $display("FAIL x0_stall got=%0b/%0b exp=0/0", st0, st1); end
        cyc(1, 0, 9, 1, 0, 10, 1, 0, 0);
        checks++; if (st0 !== 1'b0 || st1 !== 1'b0) begin errors++; $display("FAIL unused_stall got=%0b/%0b exp=0/0", st0, st1); end
        checks++; if (we0 !== 1'b0 || wr0 !== 5'd0) begin errors++; $display("FAIL x0_wb0 got=%0b/%0d exp=0/0", we0, wr0); end
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
        checks++; if (xv0 !== 1'b1 || fa0 !== 2'd0 || fb0 !== 2'd0) begin errors++; $display("FAIL unused_fwd0 got=%0b/%0d/%0d exp=1/0/0", xv0, fa0, fb0); end
        checks++; if (we0 !== 1'b1 || wr0 !== 5'd9) begin errors++; $display("FAIL x0_wb9 got=%0b/%0d exp=1/9", we0, wr0); end
    endtask

    task automatic test_redirect();
        flush();
        cyc(1, 0, 0, 0, 0, 3, 1, 0, 1);
        checks++; if (kl0 !== 1'b1 || kl1 !== 1'b1) begin errors++; $display("FAIL rd_kill_c1 got=%0b/%0b exp=1/1", kl0, kl1); end
        cyc(1, 0, 0, 0, 0, 3, 1, 0, 0);
        checks++; if (kl0 !== 1'b1 || kl1 !== 1'b0) begin errors++; $display("FAIL rd_kill_c2 got=%0b/%0b exp=1/0", kl0, kl1); end
        checks++; if (xv0 !== 1'b0) begin errors++; $display("FAIL rd_bubble1 got=%0b exp=0", xv0); end
        cyc(1, 0, 0, 0, 0, 3, 1, 0, 0);
        checks++; if (kl0 !== 1'b0) begin errors++; $display("FAIL rd_kill_c3 got=%0b exp=0", kl0); end
        checks++; if (xv0 !== 1'b0 || xv1 !== 1'b1) begin errors++; $display("FAIL rd_bubble2 got=%0b/%0b exp=0/1", xv0, xv1); end
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
        checks++; if (xv0 !== 1'b1) begin errors++; $display("FAIL rd_resume got=%0b exp=1", xv0); end
        cyc(1, 0, 0, 0, 0, 3, 1, 0, 1);
        cyc(1, 0, 0, 0, 0, 3, 1, 0, 1);
        checks++; if (kl0 !== 1'b1) begin errors++; $display("FAIL rd_reload_c2 got=%0b exp=1", kl0); end
        cyc(1, 0, 0, 0, 0, 3, 1, 0, 0);
        checks++; if (kl0 !== 1'b1) begin errors++; $display("FAIL rd_reload_c3 got=%0b exp=1", kl0); end
        cyc(1, 0, 0, 0, 0, 3, 1, 0, 0);
        checks++; if (kl0 !== 1'b0) begin errors++; $display("FAIL rd_reload_c4 got=%0b exp=0", kl0); end
    endtask

    task automatic test_redirect_stall();
        flush();
        cyc(1, 0, 0, 0, 0, 7, 1, 1, 0);
        cyc(1, 7, 0, 1, 0, 8, 1, 0, 1);
        checks++; if (st0 !== 1'b0 || kl0 !== 1'b1) begin errors++; $display("FAIL rs_prio0 got=%0b/%0b exp=0/1", st0, kl0); end
        checks++; if (st1 !== 1'b0 || kl1 !== 1'b1) begin errors++; $display("FAIL rs_prio1 got=%0b/%0b exp=0/1", st1, kl1); end
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
        checks++; if (xv0 !== 1'b0 || xv1 !== 1'b0) begin errors++; $display("FAIL rs_bubble got=%0b/%0b exp=0/0", xv0, xv1); end
    endtask

    task automatic test_async_reset();
        flush();
        cyc(1, 0, 0, 0, 0, 4, 1, 0, 0);
        cyc(1, 4, 0, 1, 0, 5, 1, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
        checks++; if (we0 !== 1'b1 || wr0 !== 5'd4 || fa0 !== 2'd1) begin errors++; $display("FAIL ar_pre got=%0b/%0d/%0d exp=1/4/1", we0, wr0, fa0); end
        #2;
        reset = 1'b1; redirect = 1'b1;
        #1;
        checks++; if (xv0 !== 1'b0 || fa0 !== 2'd0) begin errors++; $display("FAIL ar_x0 got=%0b/%0d exp=0/0", xv0, fa0); end
        checks++; if (we0 !== 1'b0 || wr0 !== 5'd0) begin errors++; $display("FAIL ar_wb0 got=%0b/%0d exp=0/0", we0, wr0); end
        checks++; if (kl0 !== 1'b0 || xv1 !== 1'b0) begin errors++; $display("FAIL ar_kill_x1 got=%0b/%0b exp=0/0", kl0, xv1); end
        @(negedge clk);
        redirect = 1'b0;
        model_clear();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
            checks++; if (we0 !== 1'b0 || we1 !== 1'b0) begin errors++; $display("FAIL ar_post%0d got=%0b/%0b exp=0/0", i, we0, we1); end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            bit ew0, ew1;
            int er0, er1;
            cyc($urandom_range(0, 3) != 0, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, int'($urandom_range(0, 3)),
                $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, $urandom_range(0, 7) == 0);
            ew0 = hist[0][2].v && hist[0][2].we && hist[0][2].rd != 0;
            er0 = hist[0][2].v ? int'(hist[0][2].rd) : 0;
            ew1 = hist[1][4].v && hist[1][4].we && hist[1][4].rd != 0;
            er1 = hist[1][4].v ? int'(hist[1][4].rd) : 0;
            checks++; if (st0 !== e_st[0] || kl0 !== e_kl[0]) begin errors++; $display("FAIL rnd_ctl0 n=%0d got=%0b/%0b exp=%0b/%0b", n, st0, kl0, e_st[0], e_kl[0]); end
            checks++; if (xv0 !== e_xv[0] || int'(fa0) != e_fa[0] || int'(fb0) != e_fb[0]) begin errors++; $display("FAIL rnd_x0 n=%0d got=%0b/%0d/%0d exp=%0b/%0d/%0d", n, xv0, fa0, fb0, e_xv[0], e_fa[0], e_fb[0]); end
            checks++; if (we0 !== ew0 || int'(wr0) != er0) begin errors++; $display("FAIL rnd_wb0 n=%0d got=%0b/%0d exp=%0b/%0d", n, we0, wr0, ew0, er0); end
            checks++; if (st1 !== e_st[1] || kl1 !== e_kl[1]) begin errors++; $display("FAIL rnd_ctl1 n=%0d got=%0b/%0b exp=%0b/%0b", n, st1, kl1, e_st[1], e_kl[1]); end
            checks++; if (xv1 !== e_xv[1] || int'(fa1) != e_fa[1] || int'(fb1) != e_fb[1]) begin errors++; $display("FAIL rnd_x1 n=%0d got=%0b/%0d/%0d exp=%0b/%0d/%0d", n, xv1, fa1, fb1, e_xv[1], e_fa[1], e_fb[1]); end
            checks++; if (we1 !== ew1 || int'(wr1) != er1) begin errors++; $display("FAIL rnd_wb1 n=%0d got=%0b/%0d exp=%0b/%0d", n, we1, wr1, ew1, er1); end
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; id_valid = 1'b0; id_rs1 = '0; id_rs2 = '0; id_rs1_used = 1'b0;
        id_rs2_used = 1'b0; id_rd = '0; id_rd_we = 1'b0; id_is_load = 1'b0; redirect = 1'b0;
        model_clear();
        test_reset();
        test_back_to_back();
        test_load_use();
        test_x0_unused();
        test_redirect();
        test_redirect_stall();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Parametrised hazard and forwarding controller for the Riscv151 pipeline, generalising the fixed bypass and kill logic in the current controller to any number of post-decode stages. It tracks the destination register of every in-flight instruction. For each decode-stage instruction it computes a registered forwarding distance per source operand, detects load-use hazards and stalls decode, and kills decode for a programmable number of cycles after a taken branch or jump. It sits beside the decoder, between stage I and the datapath bypass muxes.

## Interface
- REG_ADDR_W, 5: register address width.
- NUM_STAGES, 2: tracked stages after decode (stage 1 = X, the last stage writes the regfile); legal range 2..7.
- LOAD_LAT, 1: extra stages before load data is forwardable; must be < NUM_STAGES.
- KILL_CYCLES, 1: decode cycles killed per redirect, ≥1.
- FW = $clog2(NUM_STAGES+1): forwarding-select width.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- id_valid  in  1  decode holds a valid instruction.
- id_rs1, id_rs2  in  REG_ADDR_W  source registers.
- id_rs1_used, id_rs2_used  in  1  source is actually read.
- id_rd  in  REG_ADDR_W  destination register.
- id_rd_we  in  1  instruction writes rd.
- id_is_load  in  1  instruction is a load.
- redirect  in  1  taken branch or jump resolved in X this cycle.
- id_stall  out  1  hold PC and decode (combinational).
- id_kill  out  1  decode instruction is squashed (combinational).
- fwd_dist_a, fwd_dist_b  out  FW  registered, X-aligned operand source: 0 = regfile, d = producer d instructions older (in stage 1+d), d = NUM_STAGES = delayed writeback register.
- x_valid  out  1  stage 1 holds a real instruction.
- wb_we  out  1  valid & rd_we & rd≠0 of the last stage.
- wb_rd  out  REG_ADDR_W  rd of the last stage.

## Operation
- Stage array entries 1..NUM_STAGES, each holding {valid, rd, we, load}. All entries shift forward every cycle; stages never stall.
- Entry 1 loads {1, id_rd, id_rd_we, id_is_load} when id_valid & !id_stall & !id_kill; otherwise it loads a bubble (valid=0).
- Match at stage k for source s: s_used & s≠0 & entry k valid & we & rd==s. The youngest match (smallest k) wins.
- Load-use: a matching entry k with load=1 and k ≤ LOAD_LAT asserts id_stall. Stall is evaluated only when id_valid is high.
- Forwarding: on issue, fwd_dist_x is registered as the youngest matching k, or 0 if there is no match. fwd_dist = NUM_STAGES means the last stage writes on the same edge that the consumer enters X, so the operand comes from the delayed writeback register.
- Kill: redirect asserts id_kill the same cycle and loads kill_cnt = KILL_CYCLES−1. id_kill = redirect | (kill_cnt≠0). kill_cnt decrements to 0. A redirect while counting reloads the counter.
- Priority: redirect/kill over stall. id_stall = hazard & !id_kill.
- Registered outputs are cleared (0) when a bubble issues.
- wb_rd is forced to 0 when the last stage is invalid.

## Timing
- Reset: every entry valid=0, kill_cnt=0, fwd_dist_a/b=0, x_valid=0, wb_we=0, wb_rd=0. id_stall and id_kill are 0 while reset is held. Asserting reset mid-operation drops all in-flight state immediately.
- id_stall and id_kill depend combinationally on the current decode inputs and the stage array. There is no path from redirect to id_stall except through the kill priority.
- fwd_dist_a/b and x_valid change one edge after issue and describe the instruction now in X.
- A stalled instruction is re-evaluated every cycle. With LOAD_LAT=1, exactly one bubble is inserted and the next issue gets fwd_dist=2.
- A producer that reaches stage NUM_STAGES+1 is no longer tracked, and the regfile read is correct.
- Simultaneous match at stages 1 and 2 with no load: fwd_dist=1.

## Test plan
- Back-to-back dependence: `addi x5` then `add x6,x5,x5` (NUM_STAGES=2) → no stall; the second instruction's fwd_dist_a=fwd_dist_b=1 in X.
- Load-use: `lw x7` then `add x8,x7,x0` with LOAD_LAT=1 → id_stall=1 for exactly 1 cycle, x_valid=0 for the bubble, then fwd_dist_a=2, fwd_dist_b=0.
- x0 and unused sources: producer writes x0, consumer reads x0; also rs2 matches but id_rs2_used=0 → fwd_dist=0, no stall.
- Redirect with KILL_CYCLES=2: redirect pulse for 1 cycle → id_kill high for 2 cycles, two bubbles enter X. A second redirect in the 2nd cycle extends the kill to a 3rd cycle.
- Redirect during load-use stall → id_stall=0, id_kill=1, and the bubble issues. Sweep NUM_STAGES=4 with LOAD_LAT=2: stall 2 cycles, then fwd_dist=3.
- Asynchronous reset between clock edges with 2 valid entries → all outputs 0 before the next edge. wb_we stays 0 for NUM_STAGES cycles after release with no issue.
